// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM states, access owner, counter sizing.
// Pure declarations, no logic or latency of its own.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // The latency counter must hold MEM_LAT itself.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests; zero latency.
// Data beats fetch by default; MEM_ARB_RR_EN alternates on a tie using last_owner.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_owner,
`endif
  output logic   grant,
  output owner_e winner
);

  assign grant = if_req | dm_req;

  always_comb begin
    winner = OWN_IF;
    if (dm_req && !if_req) begin
      winner = OWN_DM;
    end else if (dm_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
`else
      winner = OWN_DM;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF and MEM stages: one access per MEM_LAT+2 cycles, ack at T+1+MEM_LAT.
// Requesters hold req until ack; stall_f/stall_m freeze the pipeline meanwhile. MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  owner_e            owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              grant;
  owner_e            winner;
  logic              done;

`ifdef MEM_ARB_RR_EN
  owner_e            last_owner;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .grant      (grant),
    .winner     (winner)
  );

  assign done = (state == WAIT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_IF;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= ISSUE;
            owner <= winner;
            if (winner == OWN_DM) begin
              cmd_we    <= dm_we;
              cmd_addr  <= dm_addr;
              cmd_wdata <= dm_wdata;
            end else begin
              cmd_we    <= 1'b0;
              cmd_addr  <= if_addr;
              cmd_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CNT_W'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= OWN_IF;
    end else if (state == IDLE && grant) begin
      last_owner <= winner;
    end
  end
`endif

  // Command stays visible on mem_addr/mem_wdata; only the strobes are gated to ISSUE.
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  assign if_ack   = done & (owner == OWN_IF);
  assign dm_ack   = done & (owner == OWN_DM);
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign dm_rdata = dm_ack ? mem_rdata : '0;

  assign stall_f = if_req & ~if_ack;
  assign stall_m = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory strobes and acks are queued with their cycle numbers.
// A negedge monitor compares every cycle; a small behavioural memory answers reads and remembers one store.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SLOT = LAT + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_ack, dm_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_f, stall_m;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic dm; logic chk_data; logic [31:0] rdata; } ack_exp_t;

  mem_exp_t exp_mem[$];
  ack_exp_t exp_ack[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural memory: read data is held from the cycle after mem_en until the next read.
  logic        st_vld = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, rd_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], 16'h5A5A};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      st_vld  <= 1'b1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end else if (mem_en) begin
      rd_data <= (st_vld && st_addr == mem_addr) ? st_data : mem_word(mem_addr);
    end
  end
  assign mem_rdata = rd_data;

  always @(negedge clk) begin : mon
    mem_exp_t me;
    ack_exp_t ae;
    logic eif, edm, emem;
    if (reset) begin
      while (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
        me = exp_mem.pop_front();
        chk("mem_en_missed", 0, 1);
      end
      while (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
        ae = exp_ack.pop_front();
        chk("ack_missed", 0, 1);
      end
      emem = (exp_mem.size() > 0 && exp_mem[0].cyc == cyc);
      eif = 1'b0;
      edm = 1'b0;
      if (exp_ack.size() > 0 && exp_ack[0].cyc == cyc) begin
        eif = !exp_ack[0].dm;
        edm = exp_ack[0].dm;
      end
      chk("mem_en", mem_en, emem);
      chk("if_ack", if_ack, eif);
      chk("dm_ack", dm_ack, edm);
      chk("stall_f", stall_f, if_req & ~eif);
      chk("stall_m", stall_m, dm_req & ~edm);
      if (!eif) chk("if_rdata_idle", if_rdata, 0);
      if (!edm) chk("dm_rdata_idle", dm_rdata, 0);
      if (emem) begin
        me = exp_mem.pop_front();
        chk("mem_we", mem_we, me.we);
        chk("mem_addr", mem_addr, me.addr);
        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
      end
      if (eif || edm) begin
        ae = exp_ack.pop_front();
        if (ae.chk_data) chk("rdata", ae.dm ? dm_rdata : if_rdata, ae.rdata);
      end
    end
  end

  // Expected access in arbitration slot k after the sampling cycle t.
  task automatic slot(input int t, input int k, input logic dm, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    mem_exp_t me;
    ack_exp_t ae;
    me.cyc = t + k * SLOT + 1; me.we = we; me.addr = addr; me.wdata = wdata;
    ae.cyc = t + k * SLOT + 1 + LAT; ae.dm = dm; ae.chk_data = !we; ae.rdata = rdata;
    exp_mem.push_back(me);
    exp_ack.push_back(ae);
  endtask

  task automatic do_if(input logic [31:0] addr, input bit keep);
    int n;
    if_req = 1'b1;
    if_addr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack && n < 40);
    if (!if_ack) chk("if_ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) if_req = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    int n;
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = addr;
    dm_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_ack && n < 40);
    if (!dm_ack) chk("dm_ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) dm_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_mem.size() != 0 || exp_ack.size() != 0 || if_req || dm_req) && n < 100);
    if (n >= 100) chk("drain_timeout", exp_mem.size() + exp_ack.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic zero_chk(input string p);
    chk({p, "_mem_en"}, mem_en, 0);
    chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_if_ack"}, if_ack, 0);
    chk({p, "_dm_ack"}, dm_ack, 0);
    chk({p, "_if_rdata"}, if_rdata, 0);
    chk({p, "_dm_rdata"}, dm_rdata, 0);
    chk({p, "_stall_f"}, stall_f, 0);
    chk({p, "_stall_m"}, stall_m, 0);
  endtask

  initial begin
    int t;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch
    t = cyc;
    slot(t, 0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0050_0093);
    do_if(32'h100, 1'b0);
    drain();

    // Simultaneous requests: data first, fetch in the next slot
    t = cyc;
    slot(t, 0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0400_5A5A);
    slot(t, 1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0104_5A5A);
    fork
      do_dm(1'b0, 32'h400, 32'h0, 1'b0);
      do_if(32'h104, 1'b0);
    join
    drain();

    // Both held continuously for two requests each
    t = cyc;
`ifdef MEM_ARB_RR_EN
    slot(t, 0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0500_5A5A);
    slot(t, 1, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0108_5A5A);
    slot(t, 2, 1'b1, 1'b0, 32'h504, 32'h0, 32'h0504_5A5A);
    slot(t, 3, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h010C_5A5A);
`else
    slot(t, 0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0500_5A5A);
    slot(t, 1, 1'b1, 1'b0, 32'h504, 32'h0, 32'h0504_5A5A);
    slot(t, 2, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0108_5A5A);
    slot(t, 3, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h010C_5A5A);
`endif
    fork
      begin do_dm(1'b0, 32'h500, 32'h0, 1'b1); do_dm(1'b0, 32'h504, 32'h0, 1'b0); end
      begin do_if(32'h108, 1'b1); do_if(32'h10C, 1'b0); end
    join
    drain();

    // Store, then load it back
    t = cyc;
    slot(t, 0, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    do_dm(1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0);
    drain();
    t = cyc;
    slot(t, 0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'hDEAD_BEEF);
    do_dm(1'b0, 32'h2000, 32'h0, 1'b0);
    drain();

    // Fetch withdrawn right after the grant; address change must not leak into the access
    t = cyc;
    slot(t, 0, 1'b0, 1'b0, 32'h110, 32'h0, 32'h0110_5A5A);
    if_req = 1'b1; if_addr = 32'h110;
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = 32'hFFFF_FFF0;
    drain();

    // Fetch pulsed only while busy: never issued
    t = cyc;
    slot(t, 0, 1'b1, 1'b0, 32'h600, 32'h0, 32'h0600_5A5A);
    fork
      do_dm(1'b0, 32'h600, 32'h0, 1'b0);
      begin
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h300;
        @(posedge clk); #1;
        if_req = 1'b0;
      end
    join
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of WAIT abandons the access
    t = cyc;
    begin
      mem_exp_t me;
      me.cyc = t + 1; me.we = 1'b0; me.addr = 32'h120; me.wdata = 32'h0;
      exp_mem.push_back(me);
    end
    if_req = 1'b1; if_addr = 32'h120;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    if_req = 1'b0;
    #1;
    zero_chk("rst_wait");
    repeat (2) @(posedge clk);
    #1;
    zero_chk("rst_hold");
    reset = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;

    t = cyc;
    slot(t, 0, 1'b0, 1'b0, 32'h124, 32'h0, 32'h0124_5A5A);
    do_if(32'h124, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch stage (IF) and the data-memory stage (MEM) of the 5-stage RISC-V pipeline. Each requester holds a request until it receives a one-cycle acknowledge. The arbiter issues one access at a time to memory with a fixed latency and returns read data. It also produces `stall_f` and `stall_m` for the hazard unit, so the pipeline freezes while its access is outstanding.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; must be ≥1
- `clk`  input  1  system clock, rising edge
- `reset`  input  1  asynchronous, active-low reset
- `if_req`  input  1  fetch request; held until `if_ack`
- `if_addr`  input  ADDR_W  fetch address
- `if_rdata`  output  DATA_W  fetched word; valid when `if_ack`
- `if_ack`  output  1  one-cycle fetch completion
- `dm_req`  input  1  data request; held until `dm_ack`
- `dm_we`  input  1  1 = store, 0 = load
- `dm_addr`  input  ADDR_W  data address
- `dm_wdata`  input  DATA_W  store data
- `dm_rdata`  output  DATA_W  load data; valid when `dm_ack`
- `dm_ack`  output  1  one-cycle data completion
- `mem_en`, `mem_we`  output  1  memory strobe and write enable
- `mem_addr`  output  ADDR_W  memory address
- `mem_wdata`  output  DATA_W  memory write data
- `mem_rdata`  input  DATA_W  memory read data
- `stall_f`, `stall_m`  output  1  combinational: `if_req & ~if_ack` and `dm_req & ~dm_ack`

## Operation
- The FSM has three states: IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any request is present, pick a winner.
  - Register its address, write enable, write data and owner.
  - Go to ISSUE on the next edge.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - Drive `mem_en`=1 for exactly one cycle, with `mem_we`/`mem_addr`/`mem_wdata` taken from the registered command.
  - Load the latency counter with MEM_LAT.
  - Go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, pulse the owner's ack, pass `mem_rdata` to the owner's rdata, and return to IDLE.
  - Stores ack on the same schedule; their rdata is don't-care.
- **Arbitration (default):** fixed priority, data over fetch.
- **Non-owner outputs:** the non-owner's ack stays 0. Its rdata is 0 whenever its ack is 0.
- **Request withdrawn before the grant** (e.g., fetch flushed by a branch): no access is issued.
- **Request withdrawn after the grant:** the access completes and ack still pulses; the requester ignores it.
- **Commands are captured once:** input changes after the grant do not affect `mem_*`.
- **Reset:**
  - State returns to IDLE and the counter to 0.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both acks and both rdata go to 0.
  - Owner returns to fetch.
  - Reset during ISSUE/WAIT abandons the in-flight access: no ack, and the late `mem_rdata` is ignored.

## Timing
- Request sampled in IDLE at cycle T → `mem_en` at T+1 → ack at T+1+MEM_LAT.
- Fastest back-to-back: a new request is sampled at T+2+MEM_LAT, giving one access per MEM_LAT+2 cycles.
- Ack is never asserted in IDLE or ISSUE.
- At most one ack is asserted per cycle.
- `stall_f`/`stall_m` are high on every cycle the respective request is pending, and low in the ack cycle.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin tie-break using a `last_owner` register, which resets to fetch.
  - When both requests are sampled in IDLE, grant the one that was not granted last.
  - A single requester is always granted.
- Undefined: fixed data-over-fetch priority, and no `last_owner` register exists.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT)
  - owner enum (OWN_IF/OWN_DM)
  - counter width constant `$clog2(MEM_LAT+1)`
- Sub-module `mem_arb_pick`: combinational winner selection from `if_req`, `dm_req` and (under `MEM_ARB_RR_EN`) `last_owner`.

## Test plan
- **Single fetch:** MEM_LAT=2, `if_req` with `if_addr`=0x100 and memory returning 0x00500093.
  - `mem_en` at T+1 with `mem_addr`=0x100.
  - `if_ack` at T+3 with `if_rdata`=0x00500093.
  - `stall_f` high at T..T+2.
- **Simultaneous requests, fixed priority:** `if_req`+`dm_req` at T.
  - Data access first (ack at T+3).
  - Fetch sampled at T+4, acked at T+7.
- **Simultaneous requests under `MEM_ARB_RR_EN`:** both requests held continuously.
  - Grants alternate DM, IF, DM, IF.
- **Store:** `dm_we`=1, `dm_addr`=0x2000, `dm_wdata`=0xDEADBEEF.
  - One `mem_en` cycle with `mem_we`=1 and the matching address/data.
  - `dm_ack` at T+3; `if_ack` stays 0.
- **Withdrawal:**
  - `if_req` dropped at T+1 after being granted at T → `if_ack` still at T+3.
  - `if_req` pulsed only while the arbiter is busy → no `mem_en` for it.
- **Reset mid-WAIT:** `reset`=0 at T+2.
  - All outputs go to 0 immediately; no ack.
  - After release, a new fetch completes normally at MEM_LAT+1 latency.
